// File: rtl/mips_fetch_pkg.sv
// Shared constants for the MIPS fetch stage: default vectors, the nop word,
// the $k0/$k1 save-select encoding and the next-PC source enumeration.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  localparam logic XP_K0 = 1'b0;
  localparam logic XP_K1 = 1'b1;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_JUMP,
    NPC_REDIR,
    NPC_IRQ,
    NPC_EXC
  } npc_sel_e;

  // Sequential successor: the mode bit is carried through untouched and the
  // low 31 bits wrap on their own.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    pc_plus4 = {pc[31], pc[30:0] + 31'd4};
  endfunction

  // The kernel bit never reaches the instruction memory.
  function automatic logic [31:0] strip_mode(input logic [31:0] pc);
    strip_mode = {1'b0, pc[30:0]};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats hold beats load; with none of them
// asserted the register keeps its contents.
module if_id_reg
  import mips_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Next contents of the stage register.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_WORD;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (hold_i) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  // Stage register with asynchronous clear to an invalid nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC register, next-PC selection and the IF/ID register.
// Optional interrupt entry is compiled in with `define FETCH_IRQ_EN; without
// it irq is ignored, xp_sel is tied to $k1 and xp_we only fires on id_exc.
module instruction_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        id_exc,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        xp_we,
  output logic        xp_sel,
  output logic [31:0] xp_data
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  npc_sel_e    npc_sel;
  logic        xp_we_c;
  logic        xp_sel_c;
  logic [31:0] xp_data_c;
  logic        ifid_flush, ifid_hold, ifid_load;

  assign pc4       = pc_plus4(pc_q);
  assign imem_addr = strip_mode(pc_q);

`ifdef FETCH_IRQ_EN
  // An interrupt is only taken in user mode and when nothing else is moving
  // the PC; otherwise it waits on the (level) line.
  logic irq_take;
  assign irq_take = irq & ~pc_q[31] & ~stall & ~id_jump & ~ex_redirect & ~id_exc;
`else
  logic unused_irq_path;
  assign unused_irq_path = ^{irq, IRQ_VEC};
`endif

  // Next-PC priority chain and return-address save request.
  always_comb begin
    pc_d      = pc_q;
    npc_sel   = NPC_SEQ;
    xp_we_c   = 1'b0;
    xp_sel_c  = XP_K1;
    xp_data_c = 32'h0;
    if (id_exc) begin
      npc_sel   = NPC_EXC;
      pc_d      = EXC_VEC;
      xp_we_c   = 1'b1;
      xp_sel_c  = XP_K1;
      xp_data_c = if_id_pc4;
    end else if (ex_redirect) begin
      npc_sel = NPC_REDIR;
      pc_d    = ex_target;
`ifdef FETCH_IRQ_EN
    end else if (irq_take) begin
      npc_sel   = NPC_IRQ;
      pc_d      = IRQ_VEC;
      xp_we_c   = 1'b1;
      xp_sel_c  = XP_K0;
      xp_data_c = pc_q;
`endif
    end else if (stall) begin
      npc_sel = NPC_HOLD;
      pc_d    = pc_q;
    end else if (id_jump) begin
      npc_sel = NPC_JUMP;
      pc_d    = id_jump_target;
    end else begin
      npc_sel = NPC_SEQ;
      pc_d    = pc4;
    end
  end

  // The save port is forced quiet while reset is held.
  always_comb begin
    xp_we   = reset & xp_we_c;
    xp_data = reset ? xp_data_c : 32'h0;
`ifdef FETCH_IRQ_EN
    xp_sel  = reset & xp_sel_c;
`else
    xp_sel  = XP_K1;
`endif
  end

  assign ifid_flush = (npc_sel == NPC_EXC) || (npc_sel == NPC_REDIR) ||
                      (npc_sel == NPC_IRQ) || (npc_sel == NPC_JUMP);
  assign ifid_hold  = (npc_sel == NPC_HOLD);
  assign ifid_load  = (npc_sel == NPC_SEQ);

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .rst_n  (reset),
    .flush_i(ifid_flush),
    .hold_i (ifid_hold),
    .load_i (ifid_load),
    .instr_i(imem_data),
    .pc4_i  (pc4),
    .instr_o(if_id_instr),
    .pc4_o  (if_id_pc4),
    .valid_o(if_id_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational instruction
// memory model whose word at address A is 32'hA500_0000 | A.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, id_jump, ex_redirect, id_exc, irq;
  logic [31:0] id_jump_target, ex_target;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic        xp_we, xp_sel;
  logic [31:0] xp_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'hA500_0000 | imem_addr;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .id_jump(id_jump),
    .id_jump_target(id_jump_target), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .id_exc(id_exc), .irq(irq),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .xp_we(xp_we), .xp_sel(xp_sel), .xp_data(xp_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; id_jump = 0; ex_redirect = 0; id_exc = 0; irq = 0;
    id_jump_target = 32'h0; ex_target = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #2;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr, 32'h0); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
    checks++; if (xp_we !== 1'b0) begin errors++; $display("FAIL rst_xpwe got=%b exp=0", xp_we); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    step();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr1 got=%h exp=%h", imem_addr, 32'h4); end
    checks++; if (if_id_instr !== 32'hA500_0000) begin errors++; $display("FAIL seq_instr1 got=%h exp=%h", if_id_instr, 32'hA500_0000); end
    checks++; if (if_id_pc4 !== 32'h8000_0004) begin errors++; $display("FAIL seq_pc4_1 got=%h exp=%h", if_id_pc4, 32'h8000_0004); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid1 got=%b exp=1", if_id_valid); end
    step();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr2 got=%h exp=%h", imem_addr, 32'h8); end
    checks++; if (if_id_instr !== 32'hA500_0004) begin errors++; $display("FAIL seq_instr2 got=%h exp=%h", if_id_instr, 32'hA500_0004); end
    checks++; if (if_id_pc4 !== 32'h8000_0008) begin errors++; $display("FAIL seq_pc4_2 got=%h exp=%h", if_id_pc4, 32'h8000_0008); end
  endtask

  task automatic test_redirect();
    ex_redirect = 1; ex_target = 32'h0000_00b4;
    step();
    ex_redirect = 0;
    checks++; if (imem_addr !== 32'h0000_00b4) begin errors++; $display("FAIL redir_addr got=%h exp=%h", imem_addr, 32'hb4); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got=%b exp=0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL redir_instr got=%h exp=0", if_id_instr); end
    step();
    checks++; if (if_id_instr !== 32'hA500_00b4) begin errors++; $display("FAIL redir_instr2 got=%h exp=%h", if_id_instr, 32'hA500_00b4); end
    checks++; if (if_id_pc4 !== 32'h0000_00b8) begin errors++; $display("FAIL redir_pc4 got=%h exp=%h", if_id_pc4, 32'hb8); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got=%b exp=1", if_id_valid); end
  endtask

  task automatic test_irq_user();
    ex_redirect = 1; ex_target = 32'h0000_0150;
    step();
    ex_redirect = 0; irq = 1;
    #1;
`ifdef FETCH_IRQ_EN
    checks++; if (xp_we !== 1'b1) begin errors++; $display("FAIL irq_xpwe got=%b exp=1", xp_we); end
    checks++; if (xp_sel !== 1'b0) begin errors++; $display("FAIL irq_xpsel got=%b exp=0", xp_sel); end
    checks++; if (xp_data !== 32'h0000_0150) begin errors++; $display("FAIL irq_xpdata got=%h exp=%h", xp_data, 32'h150); end
    step();
    irq = 0;
    checks++; if (imem_addr !== 32'h0000_0004) begin errors++; $display("FAIL irq_vec got=%h exp=%h", imem_addr, 32'h4); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL irq_flush got=%b exp=0", if_id_valid); end
    step();
    checks++; if (if_id_pc4 !== 32'h8000_0008) begin errors++; $display("FAIL irq_kpc4 got=%h exp=%h", if_id_pc4, 32'h8000_0008); end
`else
    checks++; if (xp_we !== 1'b0) begin errors++; $display("FAIL irq_off_xpwe got=%b exp=0", xp_we); end
    checks++; if (xp_sel !== 1'b1) begin errors++; $display("FAIL irq_off_xpsel got=%b exp=1", xp_sel); end
    step();
    irq = 0;
    checks++; if (imem_addr !== 32'h0000_0154) begin errors++; $display("FAIL irq_off_addr got=%h exp=%h", imem_addr, 32'h154); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL irq_off_valid got=%b exp=1", if_id_valid); end
`endif
  endtask

  task automatic test_irq_blocked();
    ex_redirect = 1; ex_target = 32'h8000_00c0;
    step();
    ex_redirect = 0; irq = 1;
    #1;
    checks++; if (xp_we !== 1'b0) begin errors++; $display("FAIL irqk_xpwe got=%b exp=0", xp_we); end
    step();
    checks++; if (imem_addr !== 32'h0000_00c4) begin errors++; $display("FAIL irqk_addr got=%h exp=%h", imem_addr, 32'hc4); end
    irq = 0; ex_redirect = 1; ex_target = 32'h0000_0200;
    step();
    ex_redirect = 0; stall = 1; irq = 1;
    #1;
    checks++; if (xp_we !== 1'b0) begin errors++; $display("FAIL irqs_xpwe got=%b exp=0", xp_we); end
    step();
    checks++; if (imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL irqs_hold got=%h exp=%h", imem_addr, 32'h200); end
    stall = 0; irq = 0;
    step();
    checks++; if (if_id_pc4 !== 32'h0000_0204) begin errors++; $display("FAIL irqs_pc4 got=%h exp=%h", if_id_pc4, 32'h204); end
  endtask

  task automatic test_exception();
    id_exc = 1; ex_redirect = 1; ex_target = 32'h0000_0300;
    #1;
    checks++; if (xp_we !== 1'b1) begin errors++; $display("FAIL exc_xpwe got=%b exp=1", xp_we); end
    checks++; if (xp_sel !== 1'b1) begin errors++; $display("FAIL exc_xpsel got=%b exp=1", xp_sel); end
    checks++; if (xp_data !== 32'h0000_0204) begin errors++; $display("FAIL exc_xpdata got=%h exp=%h", xp_data, 32'h204); end
    step();
    id_exc = 0; ex_redirect = 0;
    checks++; if (imem_addr !== 32'h0000_0008) begin errors++; $display("FAIL exc_vec got=%h exp=%h", imem_addr, 32'h8); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL exc_flush got=%b exp=0", if_id_valid); end
    step();
    checks++; if (if_id_instr !== 32'hA500_0008) begin errors++; $display("FAIL exc_instr got=%h exp=%h", if_id_instr, 32'hA500_0008); end
    checks++; if (if_id_pc4 !== 32'h8000_000c) begin errors++; $display("FAIL exc_pc4 got=%h exp=%h", if_id_pc4, 32'h8000_000c); end
  endtask

  task automatic test_stall_jump();
    stall = 1; id_jump = 1; id_jump_target = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h0000_000c) begin errors++; $display("FAIL stall_addr%0d got=%h exp=%h", i, imem_addr, 32'hc); end
      checks++; if (if_id_instr !== 32'hA500_0008) begin errors++; $display("FAIL stall_instr%0d got=%h exp=%h", i, if_id_instr, 32'hA500_0008); end
      checks++; if (if_id_pc4 !== 32'h8000_000c) begin errors++; $display("FAIL stall_pc4%0d got=%h exp=%h", i, if_id_pc4, 32'h8000_000c); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got=%b exp=1", i, if_id_valid); end
    end
    stall = 0;
    step();
    id_jump = 0;
    checks++; if (imem_addr !== 32'h0000_0400) begin errors++; $display("FAIL jump_addr got=%h exp=%h", imem_addr, 32'h400); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jump_flush got=%b exp=0", if_id_valid); end
    step();
    checks++; if (if_id_instr !== 32'hA500_0400) begin errors++; $display("FAIL jump_instr got=%h exp=%h", if_id_instr, 32'hA500_0400); end
    checks++; if (if_id_pc4 !== 32'h0000_0404) begin errors++; $display("FAIL jump_pc4 got=%h exp=%h", if_id_pc4, 32'h404); end
  endtask

  task automatic test_wrap();
    ex_redirect = 1; ex_target = 32'h7fff_fffc;
    step();
    ex_redirect = 0;
    checks++; if (imem_addr !== 32'h7fff_fffc) begin errors++; $display("FAIL wrap_addr0 got=%h exp=%h", imem_addr, 32'h7fff_fffc); end
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=0", if_id_pc4); end
    checks++; if (if_id_instr !== 32'hffff_fffc) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", if_id_instr, 32'hffff_fffc); end
    ex_redirect = 1; ex_target = 32'hffff_fffc;
    step();
    ex_redirect = 0;
    step();
    checks++; if (if_id_pc4 !== 32'h8000_0000) begin errors++; $display("FAIL wrapk_pc4 got=%h exp=%h", if_id_pc4, 32'h8000_0000); end
  endtask

  task automatic test_reset_mid();
    step();
    ex_redirect = 1; ex_target = 32'h0000_0500; id_exc = 1; irq = 1;
    #1;
    reset = 0;
    #1;
    checks++; if (xp_we !== 1'b0) begin errors++; $display("FAIL rstm_xpwe got=%b exp=0", xp_we); end
    checks++; if (xp_data !== 32'h0) begin errors++; $display("FAIL rstm_xpdata got=%h exp=0", xp_data); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rstm_addr got=%h exp=0", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rstm_valid got=%b exp=0", if_id_valid); end
    step();
    clear_inputs();
    reset = 1;
    step();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rstm_resume got=%h exp=%h", imem_addr, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_irq_user();
    test_irq_blocked();
    test_exception();
    test_stall_jump();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
